vp_frame_filler: RTL and testbench

//  Places a scaled sub-frame (scaler output stream) at a programmable window inside a full
//  H_DISP x V_DISP raster and fills everything outside the window with a background colour.

---
 rtl/vp_pkg.sv | 17 +
 rtl/vp_sync_fifo.sv | 62 ++++++
 rtl/vp_frame_filler.sv | 226 ++++++++++++++++++++++
 tb/tb_vp_frame_filler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared types and constants for the video-pipe frame filler.
package vp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VSYNC  = 2'd1,
      ST_LINE   = 2'd2,
      ST_HBLANK = 2'd3
   } vp_state_e;

   localparam logic [15:0] RGB565_BLACK = 16'h0000;
   localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
   localparam logic [15:0] RGB565_RED   = 16'hF800;
   localparam logic [15:0] RGB565_GREEN = 16'h07E0;
   localparam logic [15:0] RGB565_BLUE  = 16'h001F;

endpackage

// File: rtl/vp_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush and registered full/empty flags.
module vp_sync_fifo #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned FIFO_AW = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data_c,
   output logic              full,
   output logic              empty
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CNT_W = FIFO_AW + 1;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_nxt;
   logic               do_push;
   logic               do_pop;

   // A full FIFO still accepts a write when a read frees a slot in the same cycle.
   always_comb begin
      do_pop    = pop & ~empty;
      do_push   = push & (~full | do_pop);
      count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
      rd_data_c = mem[rd_ptr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == CNT_W'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/vp_frame_filler.sv
// Composes the scaler stream into a programmable window of a full raster, background elsewhere.
// Optional VP_FILLER_BORDER_EN adds a one-pixel cfg_border ring around the window.
module vp_frame_filler
   import vp_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned H_DISP  = 1280,
   parameter int unsigned V_DISP  = 720,
   parameter int unsigned H_BLANK = 370,
   parameter int unsigned VS_W    = 4,
   parameter int unsigned X_W     = 11,
   parameter int unsigned Y_W     = 11,
   parameter int unsigned FIFO_AW = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_en,
   input  logic [X_W-1:0]    cfg_win_x,
   input  logic [Y_W-1:0]    cfg_win_y,
   input  logic [X_W-1:0]    cfg_win_w,
   input  logic [Y_W-1:0]    cfg_win_h,
   input  logic [DATA_W-1:0] cfg_bg,
`ifdef VP_FILLER_BORDER_EN
   input  logic [DATA_W-1:0] cfg_border,
`endif
   input  logic              pre_vs,
   input  logic              pre_de,
   input  logic [DATA_W-1:0] pre_data,
   output logic              post_vs,
   output logic              post_de,
   output logic [DATA_W-1:0] post_data,
   output logic              sts_ovf,
   output logic              sts_udf
);

   localparam int unsigned XE_W    = X_W + 1;
   localparam int unsigned YE_W    = Y_W + 1;
   localparam int unsigned CNT_MAX = (VS_W > H_BLANK) ? VS_W : H_BLANK;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   vp_state_e         state;
   logic [CNT_W-1:0]  cnt;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;

   logic              pre_vs_q;
   logic              sh_en;
   logic [X_W-1:0]    sh_win_x;
   logic [Y_W-1:0]    sh_win_y;
   logic [X_W-1:0]    sh_win_w;
   logic [Y_W-1:0]    sh_win_h;
   logic [DATA_W-1:0] sh_bg;
`ifdef VP_FILLER_BORDER_EN
   logic [DATA_W-1:0] sh_border;
   logic              in_ring;
`endif

   logic              frame_start;
   logic              en_eff;
   logic [XE_W-1:0]   x_e;
   logic [YE_W-1:0]   y_e;
   logic [XE_W-1:0]   win_x_end;
   logic [YE_W-1:0]   win_y_end;
   logic              in_win;
   logic              line_act;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_rd;
   logic              ovf_ev;
   logic              udf_ev;
   logic [DATA_W-1:0] fill;
   logic [DATA_W-1:0] px;

   vp_sync_fifo #(
      .DATA_W  (DATA_W),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (frame_start),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .wr_data   (pre_data),
      .rd_data_c (fifo_rd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Window test at one extra bit so win_x + win_w never wraps; pixels past the raster are never visited.
   always_comb begin
      frame_start = pre_vs & ~pre_vs_q;
      en_eff      = frame_start ? cfg_en : sh_en;
      x_e         = XE_W'(x);
      y_e         = YE_W'(y);
      win_x_end   = XE_W'(sh_win_x) + XE_W'(sh_win_w);
      win_y_end   = YE_W'(sh_win_y) + YE_W'(sh_win_h);
      in_win      = (x_e >= XE_W'(sh_win_x)) && (x_e <= win_x_end) &&
                    (y_e >= YE_W'(sh_win_y)) && (y_e <= win_y_end);
      line_act    = sh_en & ~frame_start & (state == ST_LINE);
      fifo_pop    = line_act & in_win & ~fifo_empty;
      fifo_push   = sh_en & ~frame_start & pre_de;
      ovf_ev      = fifo_push & fifo_full & ~fifo_pop;
      udf_ev      = line_act & in_win & fifo_empty;
      fill        = sh_bg;
`ifdef VP_FILLER_BORDER_EN
      in_ring     = ((x_e + XE_W'(1)) >= XE_W'(sh_win_x)) && (x_e <= (win_x_end + XE_W'(1))) &&
                    ((y_e + YE_W'(1)) >= YE_W'(sh_win_y)) && (y_e <= (win_y_end + YE_W'(1)));
      if (in_ring && !in_win) fill = sh_border;
`endif
      px          = fifo_pop ? fifo_rd : fill;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_vs_q  <= 1'b0;
         sh_en     <= 1'b0;
         sh_win_x  <= '0;
         sh_win_y  <= '0;
         sh_win_w  <= '0;
         sh_win_h  <= '0;
         sh_bg     <= '0;
`ifdef VP_FILLER_BORDER_EN
         sh_border <= '0;
`endif
      end else begin
         pre_vs_q <= pre_vs;
         if (frame_start) begin
            sh_en     <= cfg_en;
            sh_win_x  <= cfg_win_x;
            sh_win_y  <= cfg_win_y;
            sh_win_w  <= cfg_win_w;
            sh_win_h  <= cfg_win_h;
            sh_bg     <= cfg_bg;
`ifdef VP_FILLER_BORDER_EN
            sh_border <= cfg_border;
`endif
         end
      end
   end

   // Raster sequencer; a frame-start edge restarts from VSYNC in any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         x     <= '0;
         y     <= '0;
      end else if (frame_start) begin
         state <= ST_VSYNC;
         cnt   <= '0;
         x     <= '0;
         y     <= '0;
      end else begin
         case (state)
            ST_VSYNC: begin
               if (cnt == CNT_W'(VS_W - 1)) begin
                  state <= ST_LINE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_LINE: begin
               if (x == X_W'(H_DISP - 1)) begin
                  x <= '0;
                  if (y == Y_W'(V_DISP - 1)) begin
                     state <= ST_IDLE;
                     y     <= '0;
                  end else begin
                     state <= ST_HBLANK;
                     y     <= y + Y_W'(1);
                  end
               end else begin
                  x <= x + X_W'(1);
               end
            end
            ST_HBLANK: begin
               if (cnt == CNT_W'(H_BLANK - 1)) begin
                  state <= ST_LINE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output stage: bypass mirrors the input one cycle late; the frame-start cycle itself emits nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         post_vs   <= 1'b0;
         post_de   <= 1'b0;
         post_data <= '0;
         sts_ovf   <= 1'b0;
         sts_udf   <= 1'b0;
      end else begin
         if (!en_eff) begin
            post_vs   <= pre_vs;
            post_de   <= pre_de;
            post_data <= pre_data;
         end else if (frame_start) begin
            post_vs   <= 1'b0;
            post_de   <= 1'b0;
            post_data <= '0;
         end else begin
            post_vs   <= (state == ST_VSYNC);
            post_de   <= (state == ST_LINE);
            post_data <= (state == ST_LINE) ? px : '0;
         end
         if (frame_start) begin
            sts_ovf <= 1'b0;
            sts_udf <= 1'b0;
         end else begin
            sts_ovf <= sts_ovf | ovf_ev;
            sts_udf <= sts_udf | udf_ev;
         end
      end
   end

endmodule

// File: tb/tb_vp_frame_filler.sv
// Self-checking bench for vp_frame_filler on a reduced 8x4 raster with a 16-entry FIFO.
module tb_vp_frame_filler;

   localparam int unsigned DATA_W = 16;
   localparam int H_DISP  = 8;
   localparam int V_DISP  = 4;
   localparam int H_BLANK = 4;
   localparam int VS_W    = 2;
   localparam int DEPTH   = 16;

   typedef struct {
      logic        vs;
      logic        de;
      logic [15:0] data;
   } out_t;

   typedef struct {
      int          wx;
      int          wy;
      int          ww;
      int          wh;
      logic [15:0] bg;
      int          npix;
      logic [15:0] base;
      logic        exp_ovf;
      logic        exp_udf;
   } vec_t;

   logic              clk;
   logic              rst_n;
   logic              cfg_en;
   logic [10:0]       cfg_win_x;
   logic [10:0]       cfg_win_y;
   logic [10:0]       cfg_win_w;
   logic [10:0]       cfg_win_h;
   logic [DATA_W-1:0] cfg_bg;
   logic              pre_vs;
   logic              pre_de;
   logic [DATA_W-1:0] pre_data;
   logic              post_vs;
   logic              post_de;
   logic [DATA_W-1:0] post_data;
   logic              sts_ovf;
   logic              sts_udf;

   int   n_chk;
   int   n_fail;
   out_t exp_q[$];
   out_t byp_q[$];
   vec_t vecs[4];

   vp_frame_filler #(
      .DATA_W  (DATA_W),
      .H_DISP  (H_DISP),
      .V_DISP  (V_DISP),
      .H_BLANK (H_BLANK),
      .VS_W    (VS_W),
      .X_W     (11),
      .Y_W     (11),
      .FIFO_AW (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_en    (cfg_en),
      .cfg_win_x (cfg_win_x),
      .cfg_win_y (cfg_win_y),
      .cfg_win_w (cfg_win_w),
      .cfg_win_h (cfg_win_h),
      .cfg_bg    (cfg_bg),
`ifdef VP_FILLER_BORDER_EN
      .cfg_border(16'hFFFF),
`endif
      .pre_vs    (pre_vs),
      .pre_de    (pre_de),
      .pre_data  (pre_data),
      .post_vs   (post_vs),
      .post_de   (post_de),
      .post_data (post_data),
      .sts_ovf   (sts_ovf),
      .sts_udf   (sts_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected output raster; all input pixels arrive before the first in-window position.
   function automatic void build_exp(input vec_t v);
      int   stored;
      int   idx;
      logic inwin;
      logic [15:0] d;
      exp_q.delete();
      stored = (v.npix > DEPTH) ? DEPTH : v.npix;
      idx    = 0;
      for (int i = 0; i < VS_W; i++) exp_q.push_back('{vs: 1'b1, de: 1'b0, data: 16'h0});
      for (int yy = 0; yy < V_DISP; yy++) begin
         for (int xx = 0; xx < H_DISP; xx++) begin
            inwin = (xx >= v.wx) && (xx <= v.wx + v.ww) && (yy >= v.wy) && (yy <= v.wy + v.wh);
            if (inwin && idx < stored) begin
               d = v.base + 16'(idx);
               idx++;
            end else begin
               d = v.bg;
            end
            exp_q.push_back('{vs: 1'b0, de: 1'b1, data: d});
         end
         if (yy < V_DISP - 1)
            for (int i = 0; i < H_BLANK; i++) exp_q.push_back('{vs: 1'b0, de: 1'b0, data: 16'h0});
      end
      for (int i = 0; i < 2; i++) exp_q.push_back('{vs: 1'b0, de: 1'b0, data: 16'h0});
   endfunction

   // Called at a negedge with pre_vs low; raises pre_vs for one cycle, then streams npix pixels.
   task automatic run_frame(input vec_t v, input bit chk, input int tag);
      out_t e;
      int   cyc;
      cfg_en    = 1'b1;
      cfg_win_x = 11'(v.wx);
      cfg_win_y = 11'(v.wy);
      cfg_win_w = 11'(v.ww);
      cfg_win_h = 11'(v.wh);
      cfg_bg    = v.bg;
      pre_vs    = 1'b1;
      if (chk) build_exp(v);
      @(negedge clk);
      pre_vs = 1'b0;
      if (chk) check($sformatf("frame%0d start vs/de/ovf/udf", tag),
                     {28'h0, post_vs, post_de, sts_ovf, sts_udf}, 32'h0);
      fork
         begin
            for (int i = 0; i < v.npix; i++) begin
               pre_de   = 1'b1;
               pre_data = v.base + 16'(i);
               @(negedge clk);
            end
            pre_de = 1'b0;
         end
         begin
            cyc = 0;
            if (chk) begin
               while (exp_q.size() > 0) begin
                  @(negedge clk);
                  e = exp_q.pop_front();
                  check($sformatf("frame%0d cyc%0d vs/de/data", tag, cyc),
                        {14'h0, post_vs, post_de, post_de ? post_data : 16'h0},
                        {14'h0, e.vs, e.de, e.de ? e.data : 16'h0});
                  cyc++;
               end
            end
         end
      join
      if (chk) begin
         check($sformatf("frame%0d sts_ovf", tag), {31'h0, sts_ovf}, {31'h0, v.exp_ovf});
         check($sformatf("frame%0d sts_udf", tag), {31'h0, sts_udf}, {31'h0, v.exp_udf});
      end
   endtask

   initial begin
      out_t b;
      vec_t va;
      vec_t vb;
      n_chk  = 0;
      n_fail = 0;

      //             window x,y,w,h        bg              npix  base          ovf   udf
      vecs[0] = '{wx: 2, wy: 1, ww: 3, wh: 1, bg: 16'h0000, npix: 8,  base: 16'h0001, exp_ovf: 1'b0, exp_udf: 1'b0};
      vecs[1] = '{wx: 2, wy: 1, ww: 3, wh: 1, bg: 16'hF800, npix: 4,  base: 16'h0100, exp_ovf: 1'b0, exp_udf: 1'b1};
      vecs[2] = '{wx: 0, wy: 2, ww: 7, wh: 1, bg: 16'h07E0, npix: 20, base: 16'h0200, exp_ovf: 1'b1, exp_udf: 1'b0};
      vecs[3] = '{wx: 6, wy: 3, ww: 3, wh: 3, bg: 16'h001F, npix: 4,  base: 16'h0300, exp_ovf: 1'b0, exp_udf: 1'b0};

      rst_n = 1'b0; cfg_en = 1'b0; cfg_win_x = '0; cfg_win_y = '0; cfg_win_w = '0; cfg_win_h = '0;
      cfg_bg = '0; pre_vs = 1'b0; pre_de = 1'b1; pre_data = 16'hABCD;
      repeat (3) @(negedge clk);
      check("reset outputs", {14'h0, post_vs, post_de, post_data}, 32'h0);
      check("reset stickies", {30'h0, sts_ovf, sts_udf}, 32'h0);
      pre_de = 1'b0;
      rst_n  = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 4; t++) run_frame(vecs[t], 1'b1, t);

      // Bypass: outputs are the inputs one cycle late, FIFO untouched.
      cfg_en = 1'b0; pre_vs = 1'b1; pre_de = 1'($urandom); pre_data = 16'($urandom);
      byp_q.push_back('{vs: pre_vs, de: pre_de, data: pre_data});
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         b = byp_q.pop_front();
         check($sformatf("bypass cyc%0d", i), {14'h0, post_vs, post_de, post_data}, {14'h0, b.vs, b.de, b.data});
         pre_vs = 1'($urandom); pre_de = 1'($urandom); pre_data = 16'($urandom);
         byp_q.push_back('{vs: pre_vs, de: pre_de, data: pre_data});
      end
      @(negedge clk);
      b = byp_q.pop_front();
      check("bypass last", {14'h0, post_vs, post_de, post_data}, {14'h0, b.vs, b.de, b.data});
      check("bypass stickies", {30'h0, sts_ovf, sts_udf}, 32'h0);
      pre_vs = 1'b0; pre_de = 1'b0;
      @(negedge clk);

      // Abort mid line 2: overfilled frame interrupted, new frame must see a flushed FIFO.
      va = '{wx: 0, wy: 2, ww: 1, wh: 0, bg: 16'h1234, npix: 20, base: 16'h0400, exp_ovf: 1'b1, exp_udf: 1'b0};
      vb = '{wx: 2, wy: 1, ww: 3, wh: 0, bg: 16'h4321, npix: 3,  base: 16'h0500, exp_ovf: 1'b0, exp_udf: 1'b1};
      run_frame(va, 1'b0, 10);
      repeat (10) @(negedge clk);
      check("pre-abort sts_ovf/udf", {30'h0, sts_ovf, sts_udf}, 32'h2);
      run_frame(vb, 1'b1, 11);

      // Asynchronous reset in the middle of a frame, then a clean restart.
      run_frame(vecs[0], 1'b0, 20);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid-frame reset outputs", {14'h0, post_vs, post_de, post_data}, 32'h0);
      check("mid-frame reset stickies", {30'h0, sts_ovf, sts_udf}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(vecs[0], 1'b1, 21);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
